// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared mode and state encodings for the I2S receiver
package i2s_pkg;

    localparam int MODE_LEFT  = 0;
    localparam int MODE_RIGHT = 1;
    localparam int MODE_MONO  = 2;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// rtl/i2s_pin_sync.sv - two-flop synchronizer with rising-edge detect for one I2S pin
module i2s_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            last_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~last_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: slot capture, left/right/mono sample output, lock tracking
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bclk,
    input  logic             wclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] data_out,
    output logic             stb_out,
    output logic             short_slot,
    output logic             locked
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    logic bclk_s, bit_edge;
    logic wclk_s, wclk_rise;
    logic sdata_s, sdata_rise;

    i2s_pin_sync u_bclk  (.clk(clk), .rst(rst), .pin(bclk),  .level(bclk_s),  .rise(bit_edge));
    i2s_pin_sync u_wclk  (.clk(clk), .rst(rst), .pin(wclk),  .level(wclk_s),  .rise(wclk_rise));
    i2s_pin_sync u_sdata (.clk(clk), .rst(rst), .pin(sdata), .level(sdata_s), .rise(sdata_rise));

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             prev_wclk_q;
    logic             have_prev_q;
    logic [WIDTH-1:0] left_q;
    logic             left_short_q;
    logic             left_valid_q;
    logic [TW-1:0]    tcnt_q;

    logic             timeout_hit;
    logic             wclk_chg;
    logic             has_room;
    logic [WIDTH-1:0] fill_sh;
    logic [CW-1:0]    fill_cnt;
    logic [WIDTH-1:0] aligned;
    logic             slot_short;
    logic [WIDTH:0]   mono_sum;
    logic             run_edge, drop;
    logic             close_slot, close_left, close_right;
    logic             emit;
    logic [WIDTH-1:0] result;
    logic             result_short;

    logic unused_sync;
    assign unused_sync = ^{bclk_s, wclk_rise, sdata_rise, mono_sum[0]};

    assign timeout_hit = (tcnt_q == TLIM) && !bit_edge;
    assign wclk_chg    = have_prev_q && (wclk_s != prev_wclk_q);

    // The closing edge still carries the slot's LSB (one-bit I2S delay), so fold it in before aligning.
    assign has_room   = cnt_q < FULL;
    assign fill_sh    = has_room ? WIDTH'({shreg_q, sdata_s}) : shreg_q;
    assign fill_cnt   = has_room ? cnt_q + 1'b1 : cnt_q;
    assign aligned    = fill_sh << (FULL - fill_cnt);
    assign slot_short = fill_cnt < FULL;
    assign mono_sum   = {left_q[WIDTH-1], left_q} + {aligned[WIDTH-1], aligned};

    always_comb begin
        state_d  = state_q;
        run_edge = 1'b0;
        drop     = 1'b0;
        case (state_q)
            SYNC: begin
                if (enable && bit_edge && wclk_chg) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable || timeout_hit) begin
                    state_d = SYNC;
                    drop    = 1'b1;
                end else if (bit_edge) begin
                    run_edge = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign close_slot  = run_edge && wclk_chg;
    assign close_left  = close_slot && !prev_wclk_q;
    assign close_right = close_slot && prev_wclk_q;

    assign emit = ((MODE == MODE_LEFT)  && close_left) ||
                  ((MODE == MODE_RIGHT) && close_right) ||
                  ((MODE == MODE_MONO)  && close_right && left_valid_q);

    assign result       = (MODE == MODE_MONO) ? mono_sum[WIDTH:1] : aligned;
    assign result_short = (MODE == MODE_MONO) ? (left_short_q | slot_short) : slot_short;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            shreg_q      <= '0;
            prev_wclk_q  <= 1'b0;
            have_prev_q  <= 1'b0;
            left_q       <= '0;
            left_short_q <= 1'b0;
            left_valid_q <= 1'b0;
            tcnt_q       <= '0;
            data_out     <= '0;
            stb_out      <= 1'b0;
            short_slot   <= 1'b0;
        end else begin
            stb_out <= 1'b0;

            if (bit_edge) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TLIM) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            // Losing lock forgets the last wclk level so re-lock needs a change seen afterwards.
            if (drop || !enable || timeout_hit) begin
                have_prev_q  <= 1'b0;
                cnt_q        <= '0;
                shreg_q      <= '0;
                left_valid_q <= 1'b0;
            end else if (bit_edge) begin
                prev_wclk_q <= wclk_s;
                have_prev_q <= 1'b1;
                if (state_q == SYNC || wclk_chg) begin
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end else if (has_room) begin
                    cnt_q   <= fill_cnt;
                    shreg_q <= fill_sh;
                end
                if (close_left) begin
                    left_q       <= aligned;
                    left_short_q <= slot_short;
                    left_valid_q <= 1'b1;
                end
                if (emit) begin
                    data_out   <= result;
                    short_slot <= result_short;
                    stb_out    <= 1'b1;
                end
            end
        end
    end

    assign locked = (state_q == RUN);

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed bench for i2s_rx in left and mono modes
module tb_i2s_rx;
    timeunit 1ns;
    timeprecision 1ps;

    logic clk = 1'b0;
    logic rst, enable, bclk, wclk, sdata;
    logic [15:0] data0, data2;
    logic stb0, stb2, short0, short2, locked0, locked2;

    i2s_rx #(.WIDTH(16), .MODE(0), .TIMEOUT(1023)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .bclk(bclk), .wclk(wclk), .sdata(sdata),
        .data_out(data0), .stb_out(stb0), .short_slot(short0), .locked(locked0)
    );

    i2s_rx #(.WIDTH(16), .MODE(2), .TIMEOUT(1023)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .bclk(bclk), .wclk(wclk), .sdata(sdata),
        .data_out(data2), .stb_out(stb2), .short_slot(short2), .locked(locked2)
    );

    always #2.315 clk = ~clk;

    int  n_cmp = 0;
    int  n_fail = 0;
    real bhalf = 20.0;
    logic carry = 1'b0;
    logic [16:0] q0[$];
    logic [16:0] q2[$];
    logic prev0 = 1'b0;
    logic prev2 = 1'b0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          nbits;
        bit          slow;
        logic [15:0] exp0;
        logic        exps0;
        logic [15:0] exp2;
        logic        exps2;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stb0 === 1'b1) begin
            check("m0_stb_gap", {31'd0, prev0}, 32'd0);
            q0.push_back({short0, data0});
        end
        if (stb2 === 1'b1) begin
            check("m2_stb_gap", {31'd0, prev2}, 32'd0);
            q2.push_back({short2, data2});
        end
        prev0 = (stb0 === 1'b1);
        prev2 = (stb2 === 1'b1);
    end

    task automatic pop_check(input string name, input int which, input logic [15:0] ed, input logic es);
        logic [16:0] e;
        if ((which == 0 && q0.size() == 0) || (which != 0 && q2.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got no strobe expected data %h", name, ed);
        end else begin
            if (which == 0) e = q0.pop_front();
            else e = q2.pop_front();
            check({name, "_data"}, {16'd0, e[15:0]}, {16'd0, ed});
            check({name, "_short"}, {31'd0, e[16]}, {31'd0, es});
        end
    endtask

    task automatic drive_bit(input logic w, input logic d);
        wclk = w;
        sdata = d;
        #(bhalf) bclk = 1'b1;
        #(bhalf) bclk = 1'b0;
    endtask

    // Slot position 0 carries the previous slot's LSB; data MSB starts at position 1.
    task automatic send_slot(input logic w, input logic [15:0] val, input int nbits, input int dw);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) d = carry;
            else if (i - 1 < dw) d = val[dw - i];
            else d = 1'b0;
            drive_bit(w, d);
        end
        carry = (dw >= nbits) ? val[dw - nbits] : 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h278E, 16'h1234, 32, 1'b1, 16'h278E, 1'b0, 16'h1CE1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 32, 1'b0, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        vecs[2] = '{16'h8001, 16'h0001, 32, 1'b0, 16'h8001, 1'b0, 16'hC001, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 32, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 32, 1'b0, 16'h8000, 1'b0, 16'h8000, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFE, 32, 1'b0, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0};
        vecs[6] = '{16'h0ABC, 16'h0123, 12, 1'b0, 16'hABC0, 1'b1, 16'hDEF8, 1'b1};

        rst = 1'b1; enable = 1'b1; bclk = 1'b0; wclk = 1'b1; sdata = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data0", {16'd0, data0}, 32'd0);
        check("rst_stb0", {31'd0, stb0}, 32'd0);
        check("rst_short0", {31'd0, short0}, 32'd0);
        check("rst_locked0", {31'd0, locked0}, 32'd0);
        check("rst_data2", {16'd0, data2}, 32'd0);
        check("rst_locked2", {31'd0, locked2}, 32'd0);

        // Table: preamble right slot, then one frame per vector
        send_slot(1'b1, 16'h0000, 32, 16);
        check("pre_locked", {31'd0, locked0}, 32'd0);
        for (int v = 0; v < 7; v++) begin
            bhalf = vecs[v].slow ? 162.76 : 20.0;
            send_slot(1'b0, vecs[v].l, vecs[v].nbits, (vecs[v].nbits == 12) ? 12 : 16);
            send_slot(1'b1, vecs[v].r, vecs[v].nbits, (vecs[v].nbits == 12) ? 12 : 16);
            settle();
            pop_check($sformatf("vec%0d_m0", v), 0, vecs[v].exp0, vecs[v].exps0);
            check($sformatf("vec%0d_locked", v), {31'd0, locked0}, 32'd1);
        end
        bhalf = 20.0;
        send_slot(1'b0, 16'h5555, 10, 16);
        settle();
        check("tab_m0_extra", q0.size(), 0);
        check("tab_m2_count", q2.size(), 7);
        for (int v = 0; v < 7; v++) begin
            pop_check($sformatf("vec%0d_m2", v), 2, vecs[v].exp2, vecs[v].exps2);
        end

        // BCLK stall mid-slot
        repeat (900) @(negedge clk);
        check("stall_locked_early", {31'd0, locked0}, 32'd1);
        repeat (200) @(negedge clk);
        check("stall_locked0", {31'd0, locked0}, 32'd0);
        check("stall_locked2", {31'd0, locked2}, 32'd0);
        check("stall_no_stb0", q0.size(), 0);
        check("stall_no_stb2", q2.size(), 0);
        check("stall_hold0", {16'd0, data0}, 32'h0000ABC0);
        check("stall_hold2", {16'd0, data2}, 32'h0000DEF8);
        send_slot(1'b1, 16'h1111, 32, 16);
        settle();
        check("resume_still_unlocked", {31'd0, locked0}, 32'd0);
        send_slot(1'b0, 16'h4321, 32, 16);
        settle();
        check("resume_relocked", {31'd0, locked0}, 32'd1);
        send_slot(1'b1, 16'h0F0F, 32, 16);
        send_slot(1'b0, 16'h0000, 10, 16);
        settle();
        check("resume_m0_count", q0.size(), 1);
        pop_check("resume_m0", 0, 16'h4321, 1'b0);
        check("resume_m2_count", q2.size(), 1);
        pop_check("resume_m2", 2, 16'h2918, 1'b0);

        // Reset pulse mid-left-slot
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_data0", {16'd0, data0}, 32'd0);
        check("mrst_data2", {16'd0, data2}, 32'd0);
        check("mrst_locked0", {31'd0, locked0}, 32'd0);
        check("mrst_stb0", {31'd0, stb0}, 32'd0);
        carry = 1'b0;
        send_slot(1'b0, 16'h00FF, 22, 16);
        send_slot(1'b1, 16'h9999, 32, 16);
        send_slot(1'b0, 16'h0ACE, 32, 16);
        send_slot(1'b1, 16'h0002, 32, 16);
        send_slot(1'b0, 16'h0000, 10, 16);
        settle();
        check("mrst_m0_count", q0.size(), 1);
        pop_check("mrst_m0", 0, 16'h0ACE, 1'b0);
        check("mrst_m2_count", q2.size(), 1);
        pop_check("mrst_m2", 2, 16'h0568, 1'b0);

        // Enable dropped mid-slot, raised mid-slot later
        enable = 1'b0;
        settle();
        check("dis_locked0", {31'd0, locked0}, 32'd0);
        check("dis_locked2", {31'd0, locked2}, 32'd0);
        send_slot(1'b0, 16'h0000, 22, 16);
        send_slot(1'b1, 16'h5A5A, 32, 16);
        send_slot(1'b0, 16'h0000, 8, 16);
        enable = 1'b1;
        send_slot(1'b0, 16'h7777, 24, 16);
        settle();
        check("en_partial_unlocked", {31'd0, locked0}, 32'd0);
        check("dis_no_stb0", q0.size(), 0);
        check("dis_no_stb2", q2.size(), 0);
        send_slot(1'b1, 16'h3333, 32, 16);
        send_slot(1'b0, 16'h2222, 32, 16);
        send_slot(1'b1, 16'h4444, 32, 16);
        send_slot(1'b0, 16'h0000, 10, 16);
        settle();
        check("en_m0_count", q0.size(), 1);
        pop_check("en_m0", 0, 16'h2222, 1'b0);
        check("en_m2_count", q2.size(), 1);
        pop_check("en_m2", 2, 16'h3333, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
